// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types for the instruction-fill path
package ifu_pkg;

  localparam int CL_WIDTH = 128;

  // Cache-line fill request from the i-cache miss path
  typedef struct packed {
    logic        fill_requested_address_valid;
    logic [31:0] fill_requested_address;
  } t_cache2i_mem_req;

  // Filled line returned to the i-cache
  typedef struct packed {
    logic                valid;
    logic [31:0]         address;
    logic [CL_WIDTH-1:0] filled_instruction;
  } t_i_mem2cache_rsp;

endpackage

// File: rtl/ifu_fill_ctrl.sv
// rtl/ifu_fill_ctrl.sv - i-cache line fill controller over a 32-bit instruction memory
module ifu_fill_ctrl
  import ifu_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  t_cache2i_mem_req Cache2IMemReq,
  output logic             FillReady,
  output logic             IMemRdEn,
  output logic [31:0]      IMemRdAddr,
  input  logic [31:0]      IMemRdData,
  output t_i_mem2cache_rsp IMem2CacheRsp
);

  localparam int WORDS_PER_CL = CL_WIDTH / 32;
  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_CL - 1);
  localparam logic [2:0] ALL_WORDS = 3'(WORDS_PER_CL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } t_state;

  t_state              r_state;
  logic [31:0]         r_base;
  logic [CL_WIDTH-1:0] r_line;
  logic [1:0]          r_issue_cnt;
  logic [2:0]          r_ret_cnt;
  logic                r_rd_en;
  logic [31:0]         r_rd_addr;

  // Return tags: {valid, word index}; the oldest entry lines up with IMemRdData
  logic [2:0]          r_tag [MEM_RD_LATENCY];

  logic                w_cap_vld;
  logic [1:0]          w_cap_idx;
  logic [2:0]          w_ret_cnt_nxt;
  logic                w_unused_addr_lsbs;

  // Line offset bits do not matter: the fill always starts at the line base
  assign w_unused_addr_lsbs = ^Cache2IMemReq.fill_requested_address[3:0];

  assign w_cap_vld     = r_tag[MEM_RD_LATENCY-1][2] &&
                         ((r_state == S_ISSUE) || (r_state == S_WAIT));
  assign w_cap_idx     = r_tag[MEM_RD_LATENCY-1][1:0];
  assign w_ret_cnt_nxt = r_ret_cnt + {2'b00, w_cap_vld};

  // Shift a tag in on every cycle so returning data can be matched to its word slot
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < MEM_RD_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= {r_rd_en, r_issue_cnt};
      for (int i = 1; i < MEM_RD_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Fill FSM: accept, issue four word reads, collect the returns, present the line
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_line      <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      if (w_cap_vld) begin
        r_line[{w_cap_idx, 5'd0} +: 32] <= IMemRdData;
        r_ret_cnt                       <= w_ret_cnt_nxt;
      end

      case (r_state)
        S_IDLE: begin
          if (Cache2IMemReq.fill_requested_address_valid) begin
            r_base      <= {Cache2IMemReq.fill_requested_address[31:4], 4'b0000};
            r_line      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_rd_en     <= 1'b1;
            r_rd_addr   <= {Cache2IMemReq.fill_requested_address[31:4], 4'b0000};
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (r_issue_cnt == LAST_WORD) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_state   <= S_WAIT;
          end else begin
            r_issue_cnt <= r_issue_cnt + 2'd1;
            r_rd_addr   <= r_rd_addr + 32'd4;
          end
        end

        S_WAIT: begin
          // Move on the edge that captures the last word so RESP follows immediately
          if (w_ret_cnt_nxt == ALL_WORDS) begin
            r_state <= S_RESP;
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign FillReady  = (r_state == S_IDLE);
  assign IMemRdEn   = r_rd_en;
  assign IMemRdAddr = r_rd_addr;

  // Response is decoded from the state register and forced to zero outside RESP
  always_comb begin
    IMem2CacheRsp = '0;
    if (r_state == S_RESP) begin
      IMem2CacheRsp.valid              = 1'b1;
      IMem2CacheRsp.address            = r_base;
      IMem2CacheRsp.filled_instruction = r_line;
    end
  end

endmodule

// File: tb/tb_ifu_fill_ctrl.sv
// tb/tb_ifu_fill_ctrl.sv - directed self-checking bench for ifu_fill_ctrl
module tb_ifu_fill_ctrl;
  import ifu_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Rst;
  t_cache2i_mem_req req1, req3;
  logic             rdy1, rdy3, en1, en3;
  logic [31:0]      addr1, addr3, rd1, rd3;
  t_i_mem2cache_rsp rsp1, rsp3;

  ifu_fill_ctrl #(.MEM_RD_LATENCY(1)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Cache2IMemReq(req1), .FillReady(rdy1),
    .IMemRdEn(en1), .IMemRdAddr(addr1), .IMemRdData(rd1), .IMem2CacheRsp(rsp1)
  );

  ifu_fill_ctrl #(.MEM_RD_LATENCY(3)) u_dut3 (
    .Clk(Clk), .Rst(Rst), .Cache2IMemReq(req3), .FillReady(rdy3),
    .IMemRdEn(en3), .IMemRdAddr(addr3), .IMemRdData(rd3), .IMem2CacheRsp(rsp3)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [127:0] linef(input logic [31:0] b);
    return {memf(b + 32'd12), memf(b + 32'd8), memf(b + 32'd4), memf(b)};
  endfunction

  // Memory models: latency 1 and latency 3, not reset (stale data stays in flight)
  logic [31:0] p3a, p3b;
  always @(posedge Clk) begin
    rd1 <= en1 ? memf(addr1) : 32'hDEAD_BEEF;
    p3a <= en3 ? memf(addr3) : 32'hDEAD_BEEF;
    p3b <= p3a;
    rd3 <= p3b;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int rsp_cnt1 = 0;
  int rden_cnt1 = 0;
  int rsp_cyc[$];
  always @(negedge Clk) begin
    if (rsp1.valid === 1'b1) begin
      rsp_cnt1++;
      rsp_cyc.push_back(cyc);
    end
    if (en1 === 1'b1) rden_cnt1++;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  int n0, q0, e0;

  initial begin
    Rst  = 1'b1;
    req1 = '0;
    req3 = '0;
    step(2);
    chk("rst_ready1", rdy1, 1'b1);
    chk("rst_ready3", rdy3, 1'b1);
    chk("rst_rden", en1, 1'b0);
    chk("rst_rdaddr", addr1, 32'h0);
    chk("rst_rsp_valid", rsp1.valid, 1'b0);
    chk("rst_rsp_addr", rsp1.address, 32'h0);
    chk("rst_rsp_line", rsp1.filled_instruction, 128'h0);
    Rst = 1'b0;
    step(1);

    // Single fill at 0x1238 on both latencies (cycle T)
    req1.fill_requested_address_valid = 1'b1;
    req1.fill_requested_address       = 32'h0000_1238;
    req3 = req1;
    step(1); // T+1
    chk("t1_ready_low", rdy1, 1'b0);
    chk("t1_rden_w0", en1, 1'b1);
    chk("t1_addr_w0", addr1, 32'h1230);
    chk("t1_l3_addr_w0", addr3, 32'h1230);
    req1 = '0;
    req3 = '0;
    step(1); // T+2
    chk("t1_addr_w1", addr1, 32'h1234);
    step(1); // T+3
    chk("t1_addr_w2", addr1, 32'h1238);
    step(1); // T+4
    chk("t1_rden_w3", en1, 1'b1);
    chk("t1_addr_w3", addr1, 32'h123C);
    step(1); // T+5
    chk("t1_rden_off", en1, 1'b0);
    chk("t1_rsp_early", rsp1.valid, 1'b0);
    step(1); // T+6
    chk("t1_rsp_valid", rsp1.valid, 1'b1);
    chk("t1_rsp_addr", rsp1.address, 32'h0000_1230);
    chk("t1_rsp_line", rsp1.filled_instruction,
        128'hA5A5123C_A5A51238_A5A51234_A5A51230);
    chk("t1_l3_rsp_early", rsp3.valid, 1'b0);
    step(1); // T+7
    chk("t1_rsp_single", rsp1.valid, 1'b0);
    chk("t1_rsp_line_zero", rsp1.filled_instruction, 128'h0);
    chk("t1_ready_back", rdy1, 1'b1);
    chk("t1_l3_rsp_early2", rsp3.valid, 1'b0);
    step(1); // T+8
    chk("t1_l3_rsp_valid", rsp3.valid, 1'b1);
    chk("t1_l3_rsp_addr", rsp3.address, 32'h0000_1230);
    chk("t1_l3_rsp_line", rsp3.filled_instruction,
        128'hA5A5123C_A5A51238_A5A51234_A5A51230);
    step(1); // T+9
    chk("t1_l3_rsp_single", rsp3.valid, 1'b0);
    chk("t1_l3_ready_back", rdy3, 1'b1);

    // Second request held while busy (cycle S)
    n0 = rsp_cnt1;
    req1.fill_requested_address_valid = 1'b1;
    req1.fill_requested_address       = 32'h0000_1238;
    step(1); // S+1
    req1 = '0;
    step(1); // S+2
    req1.fill_requested_address_valid = 1'b1;
    req1.fill_requested_address       = 32'h0000_2000;
    step(4); // S+6
    chk("t2_rsp1_valid", rsp1.valid, 1'b1);
    chk("t2_rsp1_addr", rsp1.address, 32'h0000_1230);
    step(1); // S+7
    chk("t2_ready_s7", rdy1, 1'b1);
    step(1); // S+8
    chk("t2_accepted", rdy1, 1'b0);
    chk("t2_addr_w0", addr1, 32'h2000);
    req1 = '0;
    step(5); // S+13
    chk("t2_rsp2_valid", rsp1.valid, 1'b1);
    chk("t2_rsp2_addr", rsp1.address, 32'h0000_2000);
    chk("t2_rsp2_line", rsp1.filled_instruction, linef(32'h2000));
    step(2); // S+15
    chk("t2_rsp_count", 128'(rsp_cnt1 - n0), 128'd2);

    // Reset in the middle of a fill (cycle R)
    req1.fill_requested_address_valid = 1'b1;
    req1.fill_requested_address       = 32'h0000_1238;
    step(1); // R+1
    req1 = '0;
    step(2); // R+3
    Rst = 1'b1;
    n0 = rsp_cnt1;
    step(1); // R+4
    Rst = 1'b0;
    chk("t3_rden_after_rst", en1, 1'b0);
    chk("t3_ready_after_rst", rdy1, 1'b1);
    req1.fill_requested_address_valid = 1'b1;
    req1.fill_requested_address       = 32'h0000_0040;
    step(1); // R+5
    req1 = '0;
    chk("t3_new_addr_w0", addr1, 32'h40);
    step(4); // R+9
    chk("t3_no_aborted_rsp", 128'(rsp_cnt1 - n0), 128'd0);
    step(1); // R+10
    chk("t3_rsp_valid", rsp1.valid, 1'b1);
    chk("t3_rsp_addr", rsp1.address, 32'h0000_0040);
    chk("t3_rsp_line", rsp1.filled_instruction,
        128'hA5A5004C_A5A50048_A5A50044_A5A50040);
    step(1); // R+11

    // Top-of-memory line
    req1.fill_requested_address_valid = 1'b1;
    req1.fill_requested_address       = 32'hFFFF_FFF4;
    step(1);
    req1 = '0;
    chk("t4_addr_w0", addr1, 32'hFFFF_FFF0);
    step(1);
    chk("t4_addr_w1", addr1, 32'hFFFF_FFF4);
    step(1);
    chk("t4_addr_w2", addr1, 32'hFFFF_FFF8);
    step(1);
    chk("t4_addr_w3", addr1, 32'hFFFF_FFFC);
    step(2);
    chk("t4_rsp_valid", rsp1.valid, 1'b1);
    chk("t4_rsp_addr", rsp1.address, 32'hFFFF_FFF0);
    chk("t4_rsp_line", rsp1.filled_instruction,
        128'h5A5AFFFC_5A5AFFF8_5A5AFFF4_5A5AFFF0);
    step(1);

    // Request held for three back-to-back fills (cycle U)
    q0 = rsp_cyc.size();
    e0 = rden_cnt1;
    req1.fill_requested_address_valid = 1'b1;
    req1.fill_requested_address       = 32'h0000_3000;
    step(15); // U+15
    req1 = '0;
    step(7);  // U+22
    chk("t5_rsp_count", 128'(rsp_cyc.size() - q0), 128'd3);
    chk("t5_gap_1_2", 128'(rsp_cyc[q0+1] - rsp_cyc[q0]), 128'd7);
    chk("t5_gap_2_3", 128'(rsp_cyc[q0+2] - rsp_cyc[q0+1]), 128'd7);
    chk("t5_rden_cycles", 128'(rden_cnt1 - e0), 128'd12);
    chk("t5_idle_end", rdy1, 1'b1);
    chk("t5_rden_end", en1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
